pipe_latch_chain: RTL and testbench

- Parametrised elastic pipeline register chain; the next generation of the team's single-stage D latch.
- Carries a WIDTH-bit word through STAGES clocked stages.
- Uses valid/ready handshakes, a global enable (stall), and a synchronous flush.
- Sits between decode sub-stages in the ISA-independent decode path; presents both true (q) and complemented (qbar) data at its output.

---
 rtl/pipe_latch_chain.sv | 123 ++++++++++++
 tb/tb_pipe_latch_chain.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_latch_chain.sv
// pipe_latch_chain: elastic valid/ready register chain carrying a WIDTH-bit word through
// STAGES clocked stages, with a global enable (stall), a synchronous flush and a
// synchronous active-high reset. The output presents both the true word and its complement.
// Optional build macro: PIPE_LATCH_OCC_EN adds the registered 'occupancy' output.
module pipe_latch_chain #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          en,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WIDTH-1:0]              d,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [WIDTH-1:0]              q,
`ifdef PIPE_LATCH_OCC_EN
  output logic [$clog2(STAGES+1)-1:0]   occupancy,
`endif
  output logic [WIDTH-1:0]              qbar
);

  if (STAGES < 1) begin : g_bad_stages
    $error("pipe_latch_chain: STAGES must be at least 1");
  end
  if (WIDTH < 1) begin : g_bad_width
    $error("pipe_latch_chain: WIDTH must be at least 1");
  end

  logic [STAGES-1:0] v_q, v_d;
  logic [STAGES-1:0] adv;
  logic [WIDTH-1:0]  r_q [STAGES];
  logic [WIDTH-1:0]  r_d [STAGES];

  // Backward ready: a stage advances when enabled and there is a hole at or below it,
  // or the output is draining. Accumulating 'room' avoids a self-referencing vector.
  always_comb begin
    logic room;
    room = out_ready;
    adv  = '0;
    for (int i = int'(STAGES) - 1; i >= 0; i--) begin
      room   = room | ~v_q[i];
      adv[i] = en & room;
    end
  end

  // Next-state: advancing stages take their upstream valid/data; data loads only when valid.
  always_comb begin
    v_d = v_q;
    r_d = r_q;
    if (flush) begin
      // Flush empties every stage; payload registers simply hold.
      v_d = '0;
    end else begin
      if (adv[0]) begin
        v_d[0] = in_valid;
        if (in_valid) begin
          r_d[0] = d;
        end
      end
      for (int i = 1; i < int'(STAGES); i++) begin
        if (adv[i]) begin
          v_d[i] = v_q[i-1];
          if (v_q[i-1]) begin
            r_d[i] = r_q[i-1];
          end
        end
      end
    end
  end

  // Stage registers; reset clears both valid bits and payloads.
  always_ff @(posedge clk) begin
    if (reset) begin
      v_q <= '0;
      for (int i = 0; i < int'(STAGES); i++) begin
        r_q[i] <= '0;
      end
    end else begin
      v_q <= v_d;
      r_q <= r_d;
    end
  end

  assign in_ready  = adv[0] & ~flush;
  assign out_valid = v_q[STAGES-1] & ~flush;
  assign q         = r_q[STAGES-1];
  assign qbar      = ~r_q[STAGES-1];

`ifdef PIPE_LATCH_OCC_EN
  logic [$clog2(STAGES+1)-1:0] occ_q, occ_d;
  logic                        push, pop;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready & en;

  // Occupancy tracks push/pop transfers; a simultaneous push and pop leaves it unchanged.
  always_comb begin
    occ_d = occ_q;
    if (flush) begin
      occ_d = '0;
    end else if (push && !pop) begin
      occ_d = occ_q + 1'b1;
    end else if (pop && !push) begin
      occ_d = occ_q - 1'b1;
    end
  end

  // Occupancy register.
  always_ff @(posedge clk) begin
    if (reset) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign occupancy = occ_q;
`endif

endmodule

// File: tb/tb_pipe_latch_chain.sv
// Bench for pipe_latch_chain: three instances (STAGES = 3, 1, 4; WIDTH = 8) share one
// stimulus stream. Each is compared every cycle against a slot-based behavioural model;
// directed steps add explicit constant checks on the STAGES=3 instance.
module tb_pipe_latch_chain;
  localparam int W    = 8;
  localparam int NI   = 3;
  localparam int SMAX = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset, en, flush, in_valid, out_ready;
  logic [W-1:0] d;
  logic         in_ready  [NI];
  logic         out_valid [NI];
  logic [W-1:0] q         [NI];
  logic [W-1:0] qbar      [NI];
`ifdef PIPE_LATCH_OCC_EN
  logic [1:0]   occ3;
  logic [0:0]   occ1;
  logic [2:0]   occ4;
`endif

  int checks = 0;
  int errors = 0;
  int ns [NI] = '{3, 1, 4};

  pipe_latch_chain #(.WIDTH(W), .STAGES(3)) u_s3 (
    .clk(clk), .reset(reset), .en(en), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready[0]), .d(d), .out_valid(out_valid[0]), .out_ready(out_ready),
    .q(q[0]),
`ifdef PIPE_LATCH_OCC_EN
    .occupancy(occ3),
`endif
    .qbar(qbar[0])
  );

  pipe_latch_chain #(.WIDTH(W), .STAGES(1)) u_s1 (
    .clk(clk), .reset(reset), .en(en), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready[1]), .d(d), .out_valid(out_valid[1]), .out_ready(out_ready),
    .q(q[1]),
`ifdef PIPE_LATCH_OCC_EN
    .occupancy(occ1),
`endif
    .qbar(qbar[1])
  );

  pipe_latch_chain #(.WIDTH(W), .STAGES(4)) u_s4 (
    .clk(clk), .reset(reset), .en(en), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready[2]), .d(d), .out_valid(out_valid[2]), .out_ready(out_ready),
    .q(q[2]),
`ifdef PIPE_LATCH_OCC_EN
    .occupancy(occ4),
`endif
    .qbar(qbar[2])
  );

  // Model: each instance is a row of slots (slot 0 nearest the input), a valid flag and a
  // payload per slot. Words shift one slot toward the output whenever the stretch of
  // slots from there to the output is not packed solid, or the output is draining.
  logic         mv [NI][SMAX];
  logic [W-1:0] mr [NI][SMAX];

  function automatic int m_count(int k);
    int c = 0;
    for (int i = 0; i < ns[k]; i++) c += int'(mv[k][i]);
    return c;
  endfunction

  function automatic logic seg_room(int k, int i);
    int filled = 0;
    for (int j = i; j < ns[k]; j++) filled += int'(mv[k][j]);
    return out_ready | (filled < ns[k] - i);
  endfunction

  function automatic logic exp_in_ready(int k);
    return en & ~flush & ((m_count(k) < ns[k]) | out_ready);
  endfunction

  task automatic model_update();
    for (int k = 0; k < NI; k++) begin
      logic mov [SMAX];
      for (int i = 0; i < SMAX; i++) mov[i] = (i < ns[k]) && en && seg_room(k, i);
      if (reset) begin
        for (int i = 0; i < SMAX; i++) begin
          mv[k][i] = 1'b0;
          mr[k][i] = '0;
        end
      end else if (flush) begin
        for (int i = 0; i < SMAX; i++) mv[k][i] = 1'b0;
      end else begin
        for (int i = ns[k] - 1; i >= 1; i--) begin
          if (mov[i]) begin
            if (mv[k][i-1]) mr[k][i] = mr[k][i-1];
            mv[k][i] = mv[k][i-1];
          end
        end
        if (mov[0]) begin
          if (in_valid) mr[k][0] = d;
          mv[k][0] = in_valid;
        end
      end
    end
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < NI; k++) begin
      logic         e_ir, e_ov;
      logic [W-1:0] e_q, e_qb;
      e_ir = exp_in_ready(k);
      e_ov = mv[k][ns[k]-1] & ~flush;
      e_q  = mr[k][ns[k]-1];
      e_qb = ~mr[k][ns[k]-1];
      chk($sformatf("in_ready S=%0d", ns[k]), {31'd0, in_ready[k]}, {31'd0, e_ir});
      chk($sformatf("out_valid S=%0d", ns[k]), {31'd0, out_valid[k]}, {31'd0, e_ov});
      chk($sformatf("q S=%0d", ns[k]), {24'd0, q[k]}, {24'd0, e_q});
      chk($sformatf("qbar S=%0d", ns[k]), {24'd0, qbar[k]}, {24'd0, e_qb});
    end
`ifdef PIPE_LATCH_OCC_EN
    chk("occupancy S=3", {30'd0, occ3}, m_count(0));
    chk("occupancy S=1", {31'd0, occ1}, m_count(1));
    chk("occupancy S=4", {29'd0, occ4}, m_count(2));
`endif
  endtask

  // One cycle: compare settled outputs, clock, advance the model.
  task automatic tick();
    #2;
    check_all();
    @(posedge clk);
    model_update();
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat [NI];
    reset = 1'b1; en = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; d = '0;
    @(posedge clk);
    model_update();
    #1;
    tick();
    reset = 1'b0;

    // Reset state
    #2;
    chk("reset out_valid", {31'd0, out_valid[0]}, 32'd0);
    chk("reset q", {24'd0, q[0]}, 32'h00);
    chk("reset qbar", {24'd0, qbar[0]}, 32'hFF);
    chk("reset in_ready", {31'd0, in_ready[0]}, 32'd1);
    tick();

    // Streaming
    out_ready = 1'b1; in_valid = 1'b1;
    d = 8'h11; tick();
    d = 8'h22; tick();
    d = 8'h33; tick();
    in_valid = 1'b0;
    #2;
    chk("stream out_valid", {31'd0, out_valid[0]}, 32'd1);
    chk("stream q0", {24'd0, q[0]}, 32'h11);
    chk("stream qbar0", {24'd0, qbar[0]}, 32'hEE);
    tick();
    #2;
    chk("stream q1", {24'd0, q[0]}, 32'h22);
    chk("stream qbar1", {24'd0, qbar[0]}, 32'hDD);
    tick();
    #2;
    chk("stream q2", {24'd0, q[0]}, 32'h33);
    chk("stream qbar2", {24'd0, qbar[0]}, 32'hCC);
    tick();
    #2;
    chk("stream drained", {31'd0, out_valid[0]}, 32'd0);
    tick();

    // Backpressure
    out_ready = 1'b0; in_valid = 1'b1;
    d = 8'hA1; tick();
    d = 8'hA2; tick();
    d = 8'hA3; tick();
    d = 8'hA4;
    #2;
    chk("bp full in_ready", {31'd0, in_ready[0]}, 32'd0);
    tick();
    #2;
    chk("bp still full", {31'd0, in_ready[0]}, 32'd0);
    chk("bp head", {24'd0, q[0]}, 32'hA1);
    tick();
    out_ready = 1'b1;
    #2;
    chk("bp pop+push in_ready", {31'd0, in_ready[0]}, 32'd1);
    chk("bp q A1", {24'd0, q[0]}, 32'hA1);
    tick();
    in_valid = 1'b0;
    #2; chk("bp q A2", {24'd0, q[0]}, 32'hA2); tick();
    #2; chk("bp q A3", {24'd0, q[0]}, 32'hA3); tick();
    #2; chk("bp q A4", {24'd0, q[0]}, 32'hA4);
    chk("bp A4 valid", {31'd0, out_valid[0]}, 32'd1); tick();

    // Stall mid-stream
    in_valid = 1'b1;
    d = 8'hE1; tick();
    d = 8'hE2; tick();
    d = 8'hE3; tick();
    en = 1'b0; d = 8'hE4;
    #2;
    chk("stall in_ready", {31'd0, in_ready[0]}, 32'd0);
    chk("stall q", {24'd0, q[0]}, 32'hE1);
    tick();
    #2;
    chk("stall q held", {24'd0, q[0]}, 32'hE1);
    chk("stall valid held", {31'd0, out_valid[0]}, 32'd1);
    tick();
    en = 1'b1;
    #2; chk("resume q E1", {24'd0, q[0]}, 32'hE1); tick();
    in_valid = 1'b0;
    #2; chk("resume q E2", {24'd0, q[0]}, 32'hE2); tick();
    #2; chk("resume q E3", {24'd0, q[0]}, 32'hE3); tick();
    #2; chk("resume q E4", {24'd0, q[0]}, 32'hE4); tick();
    #2; chk("resume drained", {31'd0, out_valid[0]}, 32'd0); tick();

    // Flush with two words in flight
    out_ready = 1'b0; in_valid = 1'b1;
    d = 8'hF1; tick();
    d = 8'hF2; tick();
    flush = 1'b1; d = 8'h5A;
    #2;
    chk("flush in_ready", {31'd0, in_ready[0]}, 32'd0);
    chk("flush out_valid", {31'd0, out_valid[0]}, 32'd0);
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int t = 0; t < 4; t++) begin
      #2;
      chk("post-flush empty", {31'd0, out_valid[0]}, 32'd0);
      tick();
    end

    // Reset with every chain full, then single-word latency
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      d = 8'hC1 + 8'(i);
      tick();
    end
    reset = 1'b1; in_valid = 1'b0;
    tick();
    reset = 1'b0;
    #2;
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("mid-reset out_valid S=%0d", ns[k]), {31'd0, out_valid[k]}, 32'd0);
      chk($sformatf("mid-reset q S=%0d", ns[k]), {24'd0, q[k]}, 32'h00);
      chk($sformatf("mid-reset qbar S=%0d", ns[k]), {24'd0, qbar[k]}, 32'hFF);
    end
    tick();
    in_valid = 1'b1; out_ready = 1'b1; d = 8'hD7;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < NI; k++) lat[k] = -1;
    for (int t = 1; t <= 6; t++) begin
      #2;
      for (int k = 0; k < NI; k++) begin
        if (lat[k] < 0 && out_valid[k] === 1'b1) lat[k] = t;
      end
      tick();
    end
    for (int k = 0; k < NI; k++) chk($sformatf("latency S=%0d", ns[k]), lat[k], ns[k]);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      reset     = ($urandom_range(0, 99) == 0);
      flush     = ($urandom_range(0, 39) == 0);
      en        = ($urandom_range(0, 4) != 0);
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      d         = 8'($urandom);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
